// File: rtl/dice_race_pkg.sv
// Shared types and constants for the dice-race board game datapath.
// Player IDs: 0 = P1, 1 = P2. Positions are 4-bit unsigned tiles.
package dice_race_pkg;

  localparam int POS_W           = 4;
  localparam int MAX_POS_DEFAULT = 10;

  typedef logic [POS_W-1:0] pos_t;

  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DONE
  } anim_state_t;

  function automatic pos_t clamp_pos(input pos_t pos, input pos_t max_pos);
    return (pos > max_pos) ? max_pos : pos;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running terminal-count counter: tick is high while the count sits at
// CYCLES-1; clear holds it at zero.
module step_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/token_animator.sv
// Walks the displayed board tokens one tile per STEP_CYCLES toward the committed
// positions. Define TOKEN_ANIM_INSTANT_EN to jump straight to the target instead.
module token_animator
  import dice_race_pkg::*;
#(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int MAX_POS     = MAX_POS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pos_valid,
  input  logic [POS_W-1:0] p1_pos,
  input  logic [POS_W-1:0] p2_pos,
  input  logic             turn,
  output logic [POS_W-1:0] disp_p1_pos,
  output logic [POS_W-1:0] disp_p2_pos,
  output logic             moving,
  output logic             active_player,
  output logic             step_tick,
  output logic             turn_done
);

  localparam pos_t MAX_P = pos_t'(MAX_POS);

  anim_state_t state_q, state_d;
  logic        pv_q;
  pos_t        target_q, target_d;
  pos_t        disp_p1_q, disp_p1_d;
  pos_t        disp_p2_q, disp_p2_d;
  logic        mover_q, mover_d;
  logic        moving_q, moving_d;
  logic        step_tick_q, step_tick_d;
  logic        turn_done_q, turn_done_d;

  logic pv_rise;
  pos_t p1_clamp, p2_clamp;
  logic p1_mis, p2_mis;
  logic trigger;
  logic trig_mover;
  pos_t trig_target, trig_disp;
  pos_t mover_disp;
  pos_t step_pos;
  logic step_now;

  assign pv_rise     = pos_valid & ~pv_q;
  assign p1_clamp    = clamp_pos(p1_pos, MAX_P);
  assign p2_clamp    = clamp_pos(p2_pos, MAX_P);
  assign p1_mis      = (p1_clamp != disp_p1_q);
  assign p2_mis      = (p2_clamp != disp_p2_q);
  assign trigger     = pv_rise | p1_mis | p2_mis;
  // An explicit move request outranks a relocation-induced mismatch
  assign trig_mover  = pv_rise ? turn : (p1_mis ? PLAYER_P1 : PLAYER_P2);
  assign trig_target = (trig_mover == PLAYER_P1) ? p1_clamp : p2_clamp;
  assign trig_disp   = (trig_mover == PLAYER_P1) ? disp_p1_q : disp_p2_q;
  assign mover_disp  = (mover_q == PLAYER_P1) ? disp_p1_q : disp_p2_q;

`ifdef TOKEN_ANIM_INSTANT_EN
  assign step_now = 1'b1;
  assign step_pos = target_q;
`else
  step_timer #(
    .CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state_q != S_MOVE),
    .tick (step_now)
  );

  assign step_pos = (target_q > mover_disp) ? mover_disp + 1'b1 : mover_disp - 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pv_q        <= 1'b0;
      target_q    <= '0;
      disp_p1_q   <= '0;
      disp_p2_q   <= '0;
      mover_q     <= PLAYER_P1;
      moving_q    <= 1'b0;
      step_tick_q <= 1'b0;
      turn_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pv_q        <= pos_valid;
      target_q    <= target_d;
      disp_p1_q   <= disp_p1_d;
      disp_p2_q   <= disp_p2_d;
      mover_q     <= mover_d;
      moving_q    <= moving_d;
      step_tick_q <= step_tick_d;
      turn_done_q <= turn_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = (trig_target == trig_disp) ? S_DONE : S_MOVE;
        end
      end
      S_MOVE: begin
        if (step_now && (step_pos == target_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    target_d    = target_q;
    mover_d     = mover_q;
    disp_p1_d   = disp_p1_q;
    disp_p2_d   = disp_p2_q;
    step_tick_d = 1'b0;
    turn_done_d = (state_q == S_DONE);
    // Stays high through the landing step so it falls together with turn_done
    moving_d    = (state_q == S_MOVE) || (state_d == S_MOVE);

    if ((state_q == S_IDLE) && trigger) begin
      target_d = trig_target;
      mover_d  = trig_mover;
    end

    if ((state_q == S_MOVE) && step_now) begin
      step_tick_d = 1'b1;
      if (mover_q == PLAYER_P1) begin
        disp_p1_d = step_pos;
      end else begin
        disp_p2_d = step_pos;
      end
    end
  end

  assign disp_p1_pos   = disp_p1_q;
  assign disp_p2_pos   = disp_p2_q;
  assign moving        = moving_q;
  assign active_player = mover_q;
  assign step_tick     = step_tick_q;
  assign turn_done     = turn_done_q;

endmodule
